// File: rtl/random_event_sched_pkg.sv
// random_sched_pkg: shared types and constants for the random event scheduler.
//   state_t     : scheduler FSM states COUNT / DRAW / WAIT
//   EV_0..EV_3  : event id constants presented on event_id
//   MISSED_MAX  : saturation value of the missed-expiry counter
package random_sched_pkg;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    DRAW  = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] EV_0 = 2'd0;
  localparam logic [1:0] EV_1 = 2'd1;
  localparam logic [1:0] EV_2 = 2'd2;
  localparam logic [1:0] EV_3 = 2'd3;

  localparam logic [3:0] MISSED_MAX = 4'd15;

endpackage

// File: rtl/random_event_sched_interval_counter.sv
// interval_counter: counts enabled timebase ticks and flags every INTERVAL-th.
// Parameters:
//   INTERVAL : ticks between expiries, legal range 1..255
// Ports:
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   enable in  high: counter advances on tick; low: counter frozen
//   tick   in  one-cycle strobe from the timebase
//   expire out high during the cycle whose enabled tick completes an interval
module interval_counter #(
  parameter int INTERVAL = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic tick,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(INTERVAL - 1);

  logic [7:0] cnt;
  logic       adv;

  assign adv = tick & enable;

  // expire is combinational so the FSM leaves COUNT on the same edge that
  // samples the completing tick.
  assign expire = adv && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (adv) begin
      if (cnt == LAST) cnt <= 8'd0;
      else             cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/random_event_sched.sv
// random_event_sched: every INTERVAL enabled ticks, samples the 2-bit LFSR
// value and presents it as a game event on a valid/ack handshake. Expiries
// that land while an event is outstanding are counted (saturating), not queued.
// Build option: define RANDOM_SCHED_NOREPEAT_EN to bump an id that would
// repeat the previous one (rnd+1 mod 4).
// Parameters:
//   INTERVAL    : timebase ticks between draws, 1..255
// Ports:
//   clk         in  system clock
//   rst         in  asynchronous active-high reset
//   enable      in  high: interval counter runs; low: frozen
//   tick        in  one-cycle timebase strobe
//   rnd         in  2-bit pseudo-random value, sampled only in DRAW
//   event_ack   in  consumer accepts the current event (honoured in WAIT)
//   event_valid out event pending
//   event_id    out event selector, stable while event_valid=1
//   missed      out saturating count of dropped expiries
module random_event_sched
  import random_sched_pkg::*;
#(
  parameter int INTERVAL = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       tick,
  input  logic [1:0] rnd,
  input  logic       event_ack,
  output logic       event_valid,
  output logic [1:0] event_id,
  output logic [3:0] missed
);

  state_t state;
  logic   expire;

`ifdef RANDOM_SCHED_NOREPEAT_EN
  logic [1:0] last_id;
  logic       has_last;

  function automatic logic [1:0] sel(input logic [1:0] r, input logic hl,
                                     input logic [1:0] last);
    // 2-bit add wraps 3 -> 0, which also makes id 0 reachable from an LFSR
    // that never produces zero.
    if (hl && (r == last)) return r + 2'd1;
    return r;
  endfunction
`else
  function automatic logic [1:0] sel(input logic [1:0] r);
    return r;
  endfunction
`endif

  interval_counter #(
    .INTERVAL (INTERVAL)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick),
    .expire (expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= COUNT;
      event_valid <= 1'b0;
      event_id    <= EV_0;
      missed      <= 4'd0;
`ifdef RANDOM_SCHED_NOREPEAT_EN
      last_id     <= EV_0;
      has_last    <= 1'b0;
`endif
    end else begin
      case (state)
        COUNT: begin
          if (expire) state <= DRAW;
        end
        DRAW: begin
`ifdef RANDOM_SCHED_NOREPEAT_EN
          event_id <= sel(rnd, has_last, last_id);
          last_id  <= sel(rnd, has_last, last_id);
          has_last <= 1'b1;
`else
          event_id <= sel(rnd);
`endif
          event_valid <= 1'b1;
          state       <= WAIT;
          if (expire && (missed != MISSED_MAX)) missed <= missed + 4'd1;
        end
        WAIT: begin
          if (event_ack) begin
            event_valid <= 1'b0;
            // An expiry coinciding with the ack is served, not dropped.
            state       <= expire ? DRAW : COUNT;
          end else if (expire && (missed != MISSED_MAX)) begin
            missed <= missed + 4'd1;
          end
        end
        default: begin
          state       <= COUNT;
          event_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_random_event_sched.sv
module tb_random_event_sched;

  localparam int INTERVAL = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] rnd = 2'd0;
  logic       event_ack = 1'b0;
  logic       event_valid;
  logic [1:0] event_id;
  logic [3:0] missed;

  int compared = 0;
  int mismatched = 0;

  random_event_sched #(.INTERVAL(INTERVAL)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .tick        (tick),
    .rnd         (rnd),
    .event_ack   (event_ack),
    .event_valid (event_valid),
    .event_id    (event_id),
    .missed      (missed)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Tracks how many enabled ticks have elapsed in the current interval,
  // whether a draw is due this cycle, whether an event is outstanding,
  // and the number of dropped expiries.
  int         m_ticks;
  bit         m_draw_due;
  bit         m_pending;
  logic [1:0] m_id;
  logic [1:0] m_last;
  bit         m_has_last;
  int         m_missed;

  function automatic logic [1:0] pick(input logic [1:0] r);
`ifdef RANDOM_SCHED_NOREPEAT_EN
    if (m_has_last && r == m_last) return r + 2'd1;
`endif
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit exp;
    if (rst) begin
      m_ticks = 0; m_draw_due = 0; m_pending = 0;
      m_id = 2'd0; m_last = 2'd0; m_has_last = 0; m_missed = 0;
    end else begin
      exp = 0;
      if (tick && enable) begin
        m_ticks = m_ticks + 1;
        if (m_ticks == INTERVAL) begin
          exp = 1;
          m_ticks = 0;
        end
      end
      if (m_draw_due) begin
        m_id = pick(rnd);
        m_last = m_id;
        m_has_last = 1;
        m_pending = 1;
        m_draw_due = 0;
        if (exp && m_missed < 15) m_missed++;
      end else if (m_pending) begin
        if (event_ack) begin
          m_pending = 0;
          m_draw_due = exp;
        end else if (exp && m_missed < 15) begin
          m_missed++;
        end
      end else if (exp) begin
        m_draw_due = 1;
      end
    end
  end

  // Compare every cycle, mid-period.
  always @(negedge clk) begin
    compared++;
    if (event_valid !== m_pending || missed !== 4'(m_missed) ||
        (m_pending && event_id !== m_id)) begin
      mismatched++;
      $display("FAIL model t=%0t: valid=%b id=%0d missed=%0d required valid=%b id=%0d missed=%0d",
               $time, event_valid, event_id, missed, m_pending, m_id, m_missed);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Drive tick/ack for one edge; returns 1 time unit after that edge.
  task automatic cyc(input bit t, input bit a);
    tick = t;
    event_ack = a;
    @(posedge clk);
    #1;
    tick = 1'b0;
    event_ack = 1'b0;
  endtask

  // One tick followed by one idle cycle.
  task automatic tk();
    cyc(1, 0);
    cyc(0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_valid", int'(event_valid), 0);
    chk("rst_missed", int'(missed), 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [1:0] exp_nr;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_valid", int'(event_valid), 0);
    chk("reset_id", int'(event_id), 0);
    chk("reset_missed", int'(missed), 0);

    // 1: tick every 4 clocks, rnd=2
    rnd = 2'd2;
    for (int i = 0; i < 2; i++) begin
      cyc(1, 0); cyc(0, 0); cyc(0, 0); cyc(0, 0);
      chk("t1_noevent", int'(event_valid), 0);
    end
    cyc(1, 0);
    chk("t1_draw_valid_low", int'(event_valid), 0);
    cyc(0, 0);
    chk("t1_valid", int'(event_valid), 1);
    chk("t1_id", int'(event_id), 2);
    cyc(0, 1);
    chk("t1_ack_drop", int'(event_valid), 0);

    // 2: pending event, missed counting and saturation
    rnd = 2'd1;
    tk(); tk(); tk();
    chk("t2_valid", int'(event_valid), 1);
    chk("t2_id", int'(event_id), 1);
    rnd = 2'd0;
    for (int i = 0; i < 2 * INTERVAL; i++) tk();
    chk("t2_missed2", int'(missed), 2);
    chk("t2_id_stable", int'(event_id), 1);
    for (int i = 0; i < 18 * INTERVAL; i++) tk();
    chk("t2_missed_sat", int'(missed), 15);
    cyc(0, 1);
    chk("t2_ack", int'(event_valid), 0);

    // 3: ack and expire together
    do_reset();
    rnd = 2'd1;
    tk(); tk(); tk();
    chk("t3_valid", int'(event_valid), 1);
    tk(); tk();
    chk("t3_missed", int'(missed), 0);
    rnd = 2'd3;
    cyc(1, 1);
    chk("t3_gap", int'(event_valid), 0);
    cyc(0, 0);
    chk("t3_revalid", int'(event_valid), 1);
    chk("t3_newid", int'(event_id), 3);
    chk("t3_missed_kept", int'(missed), 0);
    cyc(0, 1);

    // 4: enable freeze, then second draw with rnd still 3
    tk();
    enable = 1'b0;
    for (int i = 0; i < 5; i++) tk();
    chk("t4_frozen", int'(event_valid), 0);
    enable = 1'b1;
    tk();
    chk("t4_resume_noevent", int'(event_valid), 0);
    tk();
`ifdef RANDOM_SCHED_NOREPEAT_EN
    exp_nr = 2'd0;
`else
    exp_nr = 2'd3;
`endif
    chk("t4_valid", int'(event_valid), 1);
    chk("t4_repeat_id", int'(event_id), int'(exp_nr));

    // 5: reset while waiting (missed nonzero before reset)
    tk(); tk(); tk(); tk(); tk(); tk();
    chk("t5_missed_pre", int'(missed), 2);
    do_reset();
    tk(); tk();
    chk("t5_no_early", int'(event_valid), 0);
    tk();
    chk("t5_first", int'(event_valid), 1);
    chk("t5_id", int'(event_id), 3);
    cyc(0, 1);

    // 6: random traffic, checked by the model
    for (int i = 0; i < 400; i++) begin
      rnd = 2'($urandom_range(0, 3));
      enable = ($urandom_range(0, 7) != 0);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
